// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the out-of-order issue queue.
// NUM_INSTRS_COMPLETED sets the default writeback port count when not supplied by the build.
`ifndef NUM_INSTRS_COMPLETED
`define NUM_INSTRS_COMPLETED 2
`endif

package issue_queue_pkg;
  localparam int IQ_SIZE_DEFAULT = 8;
  localparam int PHYS_REGS       = 64;
  localparam int PTAG_W          = $clog2(PHYS_REGS);
  localparam int NUM_WB_DEFAULT  = `NUM_INSTRS_COMPLETED;

  typedef logic [PTAG_W-1:0] ptag_t;

  typedef enum logic [1:0] {OP_NOP, OP_ALU, OP_LOAD, OP_STORE} op_t;

  typedef struct packed {
    logic        valid;
    op_t         op;
    logic [15:0] seq;
    logic        uses_rs1;
    ptag_t       rs1;
    logic        uses_rs2;
    ptag_t       rs2;
    logic        uses_rd;
    ptag_t       rd;
  } rename_out_t;

  typedef struct packed {
    logic  valid;
    ptag_t rd;
  } wb_t;

  typedef struct packed {
    logic        valid;
    logic        rs1_rdy;
    logic        rs2_rdy;
    rename_out_t payload;
  } iq_entry_t;
endpackage

// File: rtl/issue_queue_phys_reg_ready_table.sv
// Physical-register ready bits: busy-set on rename, ready-set on writeback.
// Lookups bypass same-cycle writeback tags.
module phys_reg_ready_table
  import issue_queue_pkg::*;
#(
  parameter int NUM_WB = NUM_WB_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [1:0]           busy_en,
  input  ptag_t                busy_tag [2],
  input  wb_t                  wb [NUM_WB],
  input  ptag_t                lookup_tag [4],
  output logic [3:0]           lookup_rdy,
  output logic [PHYS_REGS-1:0] wb_hit
);
  logic [PHYS_REGS-1:0] ready_reg;
  logic [PHYS_REGS-1:0] ready_next;

  always_comb begin
    wb_hit = '0;
    for (int w = 0; w < NUM_WB; w++)
      if (wb[w].valid) wb_hit[wb[w].rd] = 1'b1;
  end

  // Busy is applied after wakeup so a same-cycle rename of the tag wins.
  always_comb begin
    ready_next = ready_reg | wb_hit;
    for (int k = 0; k < 2; k++)
      if (busy_en[k]) ready_next[busy_tag[k]] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) ready_reg <= '1;
    else                ready_reg <= ready_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lookup
      assign lookup_rdy[gi] = ready_reg[lookup_tag[gi]] | wb_hit[lookup_tag[gi]];
    end
  endgenerate
endmodule

// File: rtl/issue_queue.sv
// Issue window: dual insert, wakeup, oldest-ready select through an age matrix.
// Define IQ_PERF_CNT_EN to add the full/stall cycle counters.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int IQ_SIZE = IQ_SIZE_DEFAULT,
  parameter int NUM_WB  = `NUM_INSTRS_COMPLETED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_flush,
  input  rename_out_t i_renamed [2],
  input  wb_t         i_wb [NUM_WB],
  output logic        o_issue_valid,
  output rename_out_t o_issue,
  input  logic        i_issue_ready,
  output logic        int_stall
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0] o_full_cycles,
  output logic [31:0] o_stall_cycles
`endif
);
  localparam int IDX_W = $clog2(IQ_SIZE);
  localparam int CNT_W = $clog2(IQ_SIZE + 1);

  iq_entry_t            entry_reg [IQ_SIZE];
  iq_entry_t            entry_next [IQ_SIZE];
  logic [IQ_SIZE-1:0]   older_reg [IQ_SIZE];
  logic [IQ_SIZE-1:0]   older_next [IQ_SIZE];
  logic                 o_issue_valid_reg, o_issue_valid_next;
  rename_out_t          o_issue_reg, o_issue_next;

  logic [IQ_SIZE-1:0]   valid_vec, req_vec, grant_vec;
  logic [CNT_W-1:0]     valid_count;
  logic [IDX_W-1:0]     free0, free1, idx1;
  logic                 found0, found1;
  logic                 ins0, ins1, can_move;
  logic [3:0]           lookup_rdy;
  logic [PHYS_REGS-1:0] wb_hit;
  logic                 s0_rs1_rdy, s0_rs2_rdy, s1_rs1_rdy, s1_rs2_rdy;
  logic                 dep_rs1, dep_rs2;
  ptag_t                busy_tag [2];
  ptag_t                lookup_tag [4];

  genvar gi, gj;
  generate
    for (gi = 0; gi < IQ_SIZE; gi++) begin : g_sel
      logic [IQ_SIZE-1:0] older_col;
      for (gj = 0; gj < IQ_SIZE; gj++) begin : g_col
        assign older_col[gj] = older_reg[gj][gi];
      end
      assign valid_vec[gi] = entry_reg[gi].valid;
      assign req_vec[gi]   = entry_reg[gi].valid & entry_reg[gi].rs1_rdy & entry_reg[gi].rs2_rdy;
      assign grant_vec[gi] = req_vec[gi] & ~|(req_vec & older_col);
    end
  endgenerate

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < IQ_SIZE; i++) valid_count = valid_count + CNT_W'(valid_vec[i]);
  end

  assign int_stall = (valid_count > CNT_W'(IQ_SIZE - 2));
  assign ins0      = i_renamed[0].valid & ~int_stall & ~ext_flush;
  assign ins1      = i_renamed[1].valid & ~int_stall & ~ext_flush;
  assign can_move  = ~o_issue_valid_reg | i_issue_ready;

  always_comb begin
    free0  = '0;
    free1  = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (!valid_vec[i]) begin
        if (!found0) begin
          free0  = IDX_W'(i);
          found0 = 1'b1;
        end else if (!found1) begin
          free1  = IDX_W'(i);
          found1 = 1'b1;
        end
      end
    end
  end

  assign idx1 = ins0 ? free1 : free0;

  assign lookup_tag[0] = i_renamed[0].rs1;
  assign lookup_tag[1] = i_renamed[0].rs2;
  assign lookup_tag[2] = i_renamed[1].rs1;
  assign lookup_tag[3] = i_renamed[1].rs2;
  assign busy_tag[0]   = i_renamed[0].rd;
  assign busy_tag[1]   = i_renamed[1].rd;

  phys_reg_ready_table #(.NUM_WB(NUM_WB)) u_ready_table (
    .clk        (clk),
    .reset      (reset),
    .flush      (ext_flush),
    .busy_en    ({ins1 & i_renamed[1].uses_rd, ins0 & i_renamed[0].uses_rd}),
    .busy_tag   (busy_tag),
    .wb         (i_wb),
    .lookup_tag (lookup_tag),
    .lookup_rdy (lookup_rdy),
    .wb_hit     (wb_hit)
  );

  // Slot 1 cannot see slot 0's result in the ready table yet.
  assign dep_rs1    = ins0 & i_renamed[0].uses_rd & (i_renamed[1].rs1 == i_renamed[0].rd);
  assign dep_rs2    = ins0 & i_renamed[0].uses_rd & (i_renamed[1].rs2 == i_renamed[0].rd);
  assign s0_rs1_rdy = ~i_renamed[0].uses_rs1 | lookup_rdy[0];
  assign s0_rs2_rdy = ~i_renamed[0].uses_rs2 | lookup_rdy[1];
  assign s1_rs1_rdy = ~i_renamed[1].uses_rs1 | (lookup_rdy[2] & ~dep_rs1);
  assign s1_rs2_rdy = ~i_renamed[1].uses_rs2 | (lookup_rdy[3] & ~dep_rs2);

  always_comb begin
    entry_next         = entry_reg;
    older_next         = older_reg;
    o_issue_valid_next = o_issue_valid_reg;
    o_issue_next       = o_issue_reg;
    if (can_move) begin
      o_issue_valid_next = |grant_vec;
      for (int i = 0; i < IQ_SIZE; i++)
        if (grant_vec[i]) o_issue_next = entry_reg[i].payload;
    end
    for (int i = 0; i < IQ_SIZE; i++) begin
      if (entry_reg[i].valid) begin
        if (wb_hit[entry_reg[i].payload.rs1]) entry_next[i].rs1_rdy = 1'b1;
        if (wb_hit[entry_reg[i].payload.rs2]) entry_next[i].rs2_rdy = 1'b1;
      end
      if (can_move && grant_vec[i]) begin
        entry_next[i].valid = 1'b0;
        older_next[i]       = '0;
        for (int j = 0; j < IQ_SIZE; j++) older_next[j][i] = 1'b0;
      end
    end
    // New entries are younger than every survivor; slot 0 is older than slot 1.
    if (ins0) begin
      entry_next[free0].valid   = 1'b1;
      entry_next[free0].rs1_rdy = s0_rs1_rdy;
      entry_next[free0].rs2_rdy = s0_rs2_rdy;
      entry_next[free0].payload = i_renamed[0];
      older_next[free0]         = '0;
      for (int j = 0; j < IQ_SIZE; j++)
        older_next[j][free0] = valid_vec[j] & ~(can_move & grant_vec[j]);
    end
    if (ins1) begin
      entry_next[idx1].valid   = 1'b1;
      entry_next[idx1].rs1_rdy = s1_rs1_rdy;
      entry_next[idx1].rs2_rdy = s1_rs2_rdy;
      entry_next[idx1].payload = i_renamed[1];
      older_next[idx1]         = '0;
      for (int j = 0; j < IQ_SIZE; j++)
        older_next[j][idx1] = valid_vec[j] & ~(can_move & grant_vec[j]);
      if (ins0) older_next[free0][idx1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ext_flush) begin
      for (int i = 0; i < IQ_SIZE; i++) begin
        entry_reg[i] <= '0;
        older_reg[i] <= '0;
      end
      o_issue_valid_reg <= 1'b0;
      o_issue_reg       <= '0;
    end else begin
      entry_reg         <= entry_next;
      older_reg         <= older_next;
      o_issue_valid_reg <= o_issue_valid_next;
      o_issue_reg       <= o_issue_next;
    end
  end

  assign o_issue_valid = o_issue_valid_reg;
  assign o_issue       = o_issue_reg;

`ifdef IQ_PERF_CNT_EN
  logic [31:0] full_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (int_stall) full_cnt_reg <= full_cnt_reg + 32'd1;
      if (|valid_vec && !(|req_vec)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign o_full_cycles  = full_cnt_reg;
  assign o_stall_cycles = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus random traffic
// against an age-ordered queue model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int IQ_SIZE = IQ_SIZE_DEFAULT;
  localparam int NUM_WB  = NUM_WB_DEFAULT;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_flush;
  rename_out_t i_renamed [2];
  wb_t         i_wb [NUM_WB];
  logic        o_issue_valid;
  rename_out_t o_issue;
  logic        i_issue_ready;
  logic        int_stall;
`ifdef IQ_PERF_CNT_EN
  logic [31:0] o_full_cycles, o_stall_cycles;
`endif

  issue_queue #(.IQ_SIZE(IQ_SIZE), .NUM_WB(NUM_WB)) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_flush     (ext_flush),
    .i_renamed     (i_renamed),
    .i_wb          (i_wb),
    .o_issue_valid (o_issue_valid),
    .o_issue       (o_issue),
    .i_issue_ready (i_issue_ready),
    .int_stall     (int_stall)
`ifdef IQ_PERF_CNT_EN
    ,
    .o_full_cycles (o_full_cycles),
    .o_stall_cycles(o_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] seq_ctr = 16'd1;

  typedef struct {
    rename_out_t p;
    bit          r1;
    bit          r2;
  } ment_t;

  ment_t       mq[$];
  bit          mrdy [PHYS_REGS];
  bit          m_out_valid;
  rename_out_t m_out;

  function automatic rename_out_t mk(bit u1, int r1, bit u2, int r2, bit ud, int rd);
    rename_out_t p;
    p          = '0;
    p.valid    = 1'b1;
    p.op       = OP_ALU;
    p.seq      = seq_ctr;
    p.uses_rs1 = u1;
    p.rs1      = ptag_t'(r1);
    p.uses_rs2 = u2;
    p.rs2      = ptag_t'(r2);
    p.uses_rd  = ud;
    p.rd       = ptag_t'(rd);
    seq_ctr    = seq_ctr + 16'd1;
    return p;
  endfunction

  task automatic model_clear();
    mq.delete();
    for (int t = 0; t < PHYS_REGS; t++) mrdy[t] = 1'b1;
    m_out_valid = 1'b0;
    m_out       = '0;
  endtask

  task automatic idle();
    i_renamed[0] = '0;
    i_renamed[1] = '0;
    for (int w = 0; w < NUM_WB; w++) i_wb[w] = '0;
    ext_flush = 1'b0;
  endtask

  // One clock: advance the model with the inputs currently driven.
  task automatic cycle();
    bit    stall, ins0, ins1, found;
    ment_t e0, e1;
    bit    wbh [PHYS_REGS];
    stall = (IQ_SIZE - mq.size()) < 2;
    @(posedge clk);
    if (ext_flush) begin
      model_clear();
    end else begin
      for (int t = 0; t < PHYS_REGS; t++) wbh[t] = 1'b0;
      for (int w = 0; w < NUM_WB; w++) if (i_wb[w].valid) wbh[i_wb[w].rd] = 1'b1;
      ins0 = i_renamed[0].valid && !stall;
      ins1 = i_renamed[1].valid && !stall;
      e0.p  = i_renamed[0];
      e0.r1 = !e0.p.uses_rs1 || mrdy[e0.p.rs1] || wbh[e0.p.rs1];
      e0.r2 = !e0.p.uses_rs2 || mrdy[e0.p.rs2] || wbh[e0.p.rs2];
      e1.p  = i_renamed[1];
      e1.r1 = !e1.p.uses_rs1 || mrdy[e1.p.rs1] || wbh[e1.p.rs1];
      e1.r2 = !e1.p.uses_rs2 || mrdy[e1.p.rs2] || wbh[e1.p.rs2];
      if (ins0 && e0.p.uses_rd) begin
        if (e1.p.uses_rs1 && e1.p.rs1 == e0.p.rd) e1.r1 = 1'b0;
        if (e1.p.uses_rs2 && e1.p.rs2 == e0.p.rd) e1.r2 = 1'b0;
      end
      if (!m_out_valid || i_issue_ready) begin
        found = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].r1 && mq[i].r2) begin
            m_out = mq[i].p;
            mq.delete(i);
            found = 1'b1;
            break;
          end
        end
        m_out_valid = found;
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (wbh[mq[i].p.rs1]) mq[i].r1 = 1'b1;
        if (wbh[mq[i].p.rs2]) mq[i].r2 = 1'b1;
      end
      if (ins0) mq.push_back(e0);
      if (ins1) mq.push_back(e1);
      for (int t = 0; t < PHYS_REGS; t++) if (wbh[t]) mrdy[t] = 1'b1;
      if (ins0 && e0.p.uses_rd) mrdy[e0.p.rd] = 1'b0;
      if (ins1 && e1.p.uses_rd) mrdy[e1.p.rd] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_issue_ready = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
    total++;
    if (o_issue_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %0b expected 0", o_issue_valid);
    end
    total++;
    if (o_issue !== rename_out_t'('0)) begin
      bad++; $display("FAIL reset_payload: got %0h expected 0", o_issue);
    end
    total++;
    if (int_stall !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %0b expected 0", int_stall);
    end
    total++;
    if (dut.u_ready_table.ready_reg !== {PHYS_REGS{1'b1}}) begin
      bad++; $display("FAIL reset_ready_table: got %0h expected all ones", dut.u_ready_table.ready_reg);
    end
    $display("reset checked");
  endtask

  task automatic test_independent_pair();
    rename_out_t a, b;
    a = mk(0, 0, 0, 0, 1, 20);
    b = mk(0, 0, 0, 0, 1, 21);
    i_renamed[0] = a;
    i_renamed[1] = b;
    cycle();
    idle();
    total++;
    if (o_issue_valid !== 1'b0) begin
      bad++; $display("FAIL pair_latency: got valid %0b expected 0", o_issue_valid);
    end
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if (o_issue_valid !== (c < 2) || (c < 2 && o_issue.seq !== (c == 0 ? a.seq : b.seq))) begin
        bad++; $display("FAIL pair_issue%0d: got v=%0b seq=%0d expected v=%0b seq=%0d",
                        c, o_issue_valid, o_issue.seq, c < 2, c == 0 ? a.seq : b.seq);
      end else if (c < 2) $display("issue seq=%0d", o_issue.seq);
    end
    total++;
    if (int_stall !== 1'b0 || mq.size() != 0) begin
      bad++; $display("FAIL pair_drain: got stall %0b expected 0", int_stall);
    end
  endtask

  task automatic test_intra_pair_dep();
    rename_out_t p, d;
    p = mk(0, 0, 0, 0, 1, 10);
    d = mk(1, 10, 0, 0, 1, 11);
    i_renamed[0] = p;
    i_renamed[1] = d;
    cycle();
    idle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if (o_issue_valid !== m_out_valid || (m_out_valid && o_issue.seq !== m_out.seq)) begin
        bad++; $display("FAIL dep_wait%0d: got v=%0b seq=%0d expected v=%0b seq=%0d",
                        c, o_issue_valid, o_issue.seq, m_out_valid, m_out.seq);
      end
    end
    total++;
    if (o_issue_valid !== 1'b0) begin
      bad++; $display("FAIL dep_blocked: got valid %0b expected 0", o_issue_valid);
    end
    i_wb[0] = '{valid: 1'b1, rd: ptag_t'(10)};
    cycle();
    idle();
    total++;
    if (o_issue_valid !== 1'b0) begin
      bad++; $display("FAIL dep_wb_early: got valid %0b expected 0", o_issue_valid);
    end
    cycle();
    total++;
    if (o_issue_valid !== 1'b1 || o_issue.seq !== d.seq) begin
      bad++; $display("FAIL dep_wakeup: got v=%0b seq=%0d expected v=1 seq=%0d",
                      o_issue_valid, o_issue.seq, d.seq);
    end else $display("issue seq=%0d after wakeup", o_issue.seq);
    cycle();
  endtask

  task automatic test_fill_stall();
    logic [15:0] first_w;
    logic [15:0] first_seen;
    bit          seen;
    i_renamed[0] = mk(0, 0, 0, 0, 1, 40);
    i_renamed[1] = mk(1, 40, 0, 0, 0, 0);
    first_w = i_renamed[1].seq;
    cycle();
    for (int k = 0; k < 3; k++) begin
      i_renamed[0] = mk(1, 40, 0, 0, 0, 0);
      i_renamed[1] = mk(0, 0, 1, 40, 0, 0);
      cycle();
    end
    i_renamed[0] = mk(0, 0, 0, 0, 0, 0);
    i_renamed[1] = mk(0, 0, 0, 0, 0, 0);
    total++;
    if (int_stall !== 1'b1) begin
      bad++; $display("FAIL fill_stall: got %0b expected 1", int_stall);
    end
    for (int c = 0; c < 2; c++) begin
      cycle();
      total++;
      if (int_stall !== 1'b1 || o_issue_valid !== 1'b0 || mq.size() != 7) begin
        bad++; $display("FAIL fill_hold%0d: got stall=%0b v=%0b expected stall=1 v=0",
                        c, int_stall, o_issue_valid);
      end
    end
    i_wb[NUM_WB-1] = '{valid: 1'b1, rd: ptag_t'(40)};
    cycle();
    i_wb[NUM_WB-1] = '0;
    seen = 1'b0;
    first_seen = '0;
    for (int c = 0; c < 14; c++) begin
      if (c == 2) idle();
      total++;
      if (int_stall !== ((IQ_SIZE - mq.size()) < 2)) begin
        bad++; $display("FAIL fill_drain_stall%0d: got %0b expected %0b",
                        c, int_stall, (IQ_SIZE - mq.size()) < 2);
      end
      cycle();
      total++;
      if (o_issue_valid !== m_out_valid || (m_out_valid && o_issue.seq !== m_out.seq)) begin
        bad++; $display("FAIL fill_drain%0d: got v=%0b seq=%0d expected v=%0b seq=%0d",
                        c, o_issue_valid, o_issue.seq, m_out_valid, m_out.seq);
      end
      if (o_issue_valid && !seen) begin
        seen = 1'b1;
        first_seen = o_issue.seq;
      end
    end
    total++;
    if (first_seen !== first_w) begin
      bad++; $display("FAIL fill_oldest_first: got seq=%0d expected seq=%0d", first_seen, first_w);
    end
  endtask

  task automatic test_hold_output();
    rename_out_t a, b;
    a = mk(0, 0, 0, 0, 0, 0);
    b = mk(0, 0, 0, 0, 0, 0);
    i_issue_ready = 1'b0;
    i_renamed[0] = a;
    cycle();
    i_renamed[0] = b;
    cycle();
    idle();
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if (o_issue_valid !== 1'b1 || o_issue.seq !== a.seq) begin
        bad++; $display("FAIL hold%0d: got v=%0b seq=%0d expected v=1 seq=%0d",
                        c, o_issue_valid, o_issue.seq, a.seq);
      end
    end
    i_issue_ready = 1'b1;
    cycle();
    total++;
    if (o_issue_valid !== 1'b1 || o_issue.seq !== b.seq) begin
      bad++; $display("FAIL hold_next: got v=%0b seq=%0d expected v=1 seq=%0d",
                      o_issue_valid, o_issue.seq, b.seq);
    end else $display("issue seq=%0d after release", o_issue.seq);
    cycle();
  endtask

  task automatic test_wb_bypass();
    rename_out_t c5;
    i_renamed[0] = mk(0, 0, 0, 0, 1, 5);
    cycle();
    idle();
    repeat (2) cycle();
    c5 = mk(1, 5, 0, 0, 0, 0);
    i_renamed[0] = c5;
    i_wb[0] = '{valid: 1'b1, rd: ptag_t'(5)};
    cycle();
    idle();
    cycle();
    total++;
    if (o_issue_valid !== 1'b1 || o_issue.seq !== c5.seq) begin
      bad++; $display("FAIL wb_bypass: got v=%0b seq=%0d expected v=1 seq=%0d",
                      o_issue_valid, o_issue.seq, c5.seq);
    end else $display("issue seq=%0d via bypass", o_issue.seq);
    cycle();
  endtask

  task automatic test_flush();
    i_issue_ready = 1'b0;
    i_renamed[0] = mk(0, 0, 0, 0, 1, 50);
    i_renamed[1] = mk(1, 50, 0, 0, 0, 0);
    cycle();
    for (int k = 0; k < 2; k++) begin
      i_renamed[0] = mk(1, 50, 0, 0, 1, 51 + k);
      i_renamed[1] = mk(0, 0, 1, 50, 0, 0);
      cycle();
    end
    total++;
    if (o_issue_valid !== 1'b1 || int_stall !== 1'b0 || mq.size() != 5) begin
      bad++; $display("FAIL flush_setup: got v=%0b stall=%0b expected v=1 stall=0",
                      o_issue_valid, int_stall);
    end
    ext_flush = 1'b1;
    i_renamed[0] = mk(0, 0, 0, 0, 1, 60);
    cycle();
    idle();
    total++;
    if (o_issue_valid !== 1'b0 || int_stall !== 1'b0) begin
      bad++; $display("FAIL flush_clear: got v=%0b stall=%0b expected v=0 stall=0",
                      o_issue_valid, int_stall);
    end
    total++;
    if (dut.u_ready_table.ready_reg !== {PHYS_REGS{1'b1}}) begin
      bad++; $display("FAIL flush_ready_table: got %0h expected all ones", dut.u_ready_table.ready_reg);
    end
    i_issue_ready = 1'b1;
    repeat (2) cycle();
    total++;
    if (o_issue_valid !== 1'b0) begin
      bad++; $display("FAIL flush_empty: got v=%0b expected 0", o_issue_valid);
    end
    $display("flush checked");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(1, 0) == 1)
          i_renamed[k] = mk($urandom_range(1, 0), $urandom_range(15, 0),
                            $urandom_range(1, 0), $urandom_range(15, 0),
                            $urandom_range(1, 0), $urandom_range(15, 0));
        else
          i_renamed[k] = '0;
      end
      for (int w = 0; w < NUM_WB; w++) begin
        i_wb[w].valid = ($urandom_range(2, 0) == 0);
        i_wb[w].rd    = ptag_t'($urandom_range(15, 0));
      end
      i_issue_ready = ($urandom_range(3, 0) != 0);
      ext_flush     = ($urandom_range(63, 0) == 0);
      total++;
      if (int_stall !== ((IQ_SIZE - mq.size()) < 2)) begin
        bad++; $display("FAIL rand_stall%0d: got %0b expected %0b", c, int_stall, (IQ_SIZE - mq.size()) < 2);
      end
      cycle();
      total++;
      if (o_issue_valid !== m_out_valid || (m_out_valid && o_issue.seq !== m_out.seq)) begin
        bad++; $display("FAIL rand_issue%0d: got v=%0b seq=%0d expected v=%0b seq=%0d",
                        c, o_issue_valid, o_issue.seq, m_out_valid, m_out.seq);
      end else if (o_issue_valid && i_issue_ready) $display("rand issue seq=%0d", o_issue.seq);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_independent_pair();
    test_intra_pair_dep();
    test_fill_stall();
    test_hold_output();
    test_wb_bypass();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
